// File: rtl/i2s_frame_tx.sv
// I2S frame serializer: one stereo sample per frame through a one-entry holding buffer.
// Build option: define I2S_UNDERRUN_MUTE_EN to send silence on underrun instead of a repeat.
module i2s_frame_tx #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             ws,
    output logic             sdata,
    output logic             frame_start,
    output logic             underrun,
    output logic             underrun_sticky
);

    localparam int unsigned SLOTS = 2 * WIDTH;
    localparam int unsigned KW    = $clog2(SLOTS);

    localparam logic [KW-1:0] KLast   = KW'(SLOTS - 1);
    localparam logic [KW-1:0] KRight  = KW'(WIDTH);
    localparam logic [KW-1:0] KWsRise = KW'(WIDTH - 1);
    localparam logic [KW-1:0] KWsFall = KW'(SLOTS - 2);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  hold_l_q, hold_l_d;
    logic [WIDTH-1:0]  hold_r_q, hold_r_d;
    logic              hold_full_q, hold_full_d;
    logic [WIDTH-1:0]  shift_l_q, shift_l_d;
    logic [WIDTH-1:0]  shift_r_q, shift_r_d;
    logic              ws_q, ws_d;
    logic              sdata_q, sdata_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q, underrun_d;
    logic              sticky_q, sticky_d;
`ifndef I2S_UNDERRUN_MUTE_EN
    logic [WIDTH-1:0]  last_l_q, last_l_d;
    logic [WIDTH-1:0]  last_r_q, last_r_d;
`endif

    logic              accept;
    logic              load_frame;
    logic              load_hold;
    logic [WIDTH-1:0]  frame_l;
    logic [WIDTH-1:0]  frame_r;

    assign accept = valid_in && !hold_full_q;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        hold_full_d   = hold_full_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        sdata_d       = sdata_q;
        ws_d          = 1'b0;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        sticky_d      = sticky_q;
`ifndef I2S_UNDERRUN_MUTE_EN
        last_l_d      = last_l_q;
        last_r_d      = last_r_q;
`endif
        load_frame    = 1'b0;
        load_hold     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    state_d    = StRun;
                    load_frame = 1'b1;
                    load_hold  = 1'b1;
                end
            end
            StRun: begin
                if (k_q == KLast) begin
                    load_frame = 1'b1;
                    if (hold_full_q) begin
                        load_hold = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Underrun frames replay the last pair, or silence in the mute build.
        if (load_hold) begin
            frame_l = hold_l_q;
            frame_r = hold_r_q;
        end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
            frame_l = '0;
            frame_r = '0;
`else
            frame_l = last_l_q;
            frame_r = last_r_q;
`endif
        end

        if (load_frame) begin
            k_d           = '0;
            sdata_d       = frame_l[WIDTH-1];
            shift_l_d     = frame_l << 1;
            shift_r_d     = frame_r;
            frame_start_d = 1'b1;
        end else if (state_q == StRun) begin
            k_d = k_q + KW'(1);
            if (k_d < KRight) begin
                sdata_d   = shift_l_q[WIDTH-1];
                shift_l_d = shift_l_q << 1;
            end else begin
                sdata_d   = shift_r_q[WIDTH-1];
                shift_r_d = shift_r_q << 1;
            end
        end

        // ws leads the word it selects by one slot: high from left LSB through right LSB-1.
        if (state_d == StRun) begin
            ws_d = (k_d >= KWsRise) && (k_d <= KWsFall);
        end

        if (load_hold) begin
            hold_full_d = 1'b0;
`ifndef I2S_UNDERRUN_MUTE_EN
            last_l_d    = hold_l_q;
            last_r_d    = hold_r_q;
`endif
        end

        // Accept and load are exclusive: a load needs a full buffer, accept an empty one.
        if (accept) begin
            hold_l_d    = left_in;
            hold_r_d    = right_in;
            hold_full_d = 1'b1;
        end

        if (underrun_d) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q       <= StIdle;
            k_q           <= '0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            hold_full_q   <= 1'b0;
            shift_l_q     <= '0;
            shift_r_q     <= '0;
            ws_q          <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            sticky_q      <= 1'b0;
`ifndef I2S_UNDERRUN_MUTE_EN
            last_l_q      <= '0;
            last_r_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            hold_full_q   <= hold_full_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
            ws_q          <= ws_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            sticky_q      <= sticky_d;
`ifndef I2S_UNDERRUN_MUTE_EN
            last_l_q      <= last_l_d;
            last_r_q      <= last_r_d;
`endif
        end
    end

    assign ready_out       = !hold_full_q;
    assign ws              = ws_q;
    assign sdata           = sdata_q;
    assign frame_start     = frame_start_q;
    assign underrun        = underrun_q;
    assign underrun_sticky = sticky_q;

`ifndef SYNTHESIS
    a_underrun_at_start : assert property (@(posedge sclk) disable iff (rst)
        underrun |-> frame_start);
    a_ws_low_at_start : assert property (@(posedge sclk) disable iff (rst)
        frame_start |-> !ws);
`endif

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Self-checking bench for i2s_frame_tx: a frame-level reference model predicts every output
// each cycle; scenario tasks also decode whole frames and check the spec's boundary cases.
module tb_i2s_frame_tx;

    localparam int W = 16;
`ifdef I2S_UNDERRUN_MUTE_EN
    localparam bit Mute = 1'b1;
`else
    localparam bit Mute = 1'b0;
`endif

    logic         sclk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] left_in = '0;
    logic [W-1:0] right_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_out, ws, sdata, frame_start, underrun, underrun_sticky;

    int vectors = 0;
    int miscompares = 0;

    i2s_frame_tx #(.WIDTH(W)) dut (
        .sclk            (sclk),
        .rst             (rst),
        .left_in         (left_in),
        .right_in        (right_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .ws              (ws),
        .sdata           (sdata),
        .frame_start     (frame_start),
        .underrun        (underrun),
        .underrun_sticky (underrun_sticky)
    );

    always #5 sclk = ~sclk;

    // Reference model: frame-level state, outputs derived from the slot-mapping rules.
    bit           m_run;
    int           m_slot;
    logic [W-1:0] m_cur_l, m_cur_r, m_last_l, m_last_r, m_hold_l, m_hold_r;
    bit           m_hold_full, m_under, m_sticky;

    task automatic model_step();
        bit acc;
        if (rst) begin
            m_run = 0; m_slot = 0; m_hold_full = 0; m_under = 0; m_sticky = 0;
            m_cur_l = '0; m_cur_r = '0; m_last_l = '0; m_last_r = '0;
        end else begin
            acc = valid_in && !m_hold_full;
            m_under = 0;
            if (!m_run) begin
                if (m_hold_full) begin
                    m_run = 1; m_slot = 0;
                    m_cur_l = m_hold_l; m_cur_r = m_hold_r;
                    m_last_l = m_hold_l; m_last_r = m_hold_r;
                    m_hold_full = 0;
                end
            end else if (m_slot == 2 * W - 1) begin
                m_slot = 0;
                if (m_hold_full) begin
                    m_cur_l = m_hold_l; m_cur_r = m_hold_r;
                    m_last_l = m_hold_l; m_last_r = m_hold_r;
                    m_hold_full = 0;
                end else begin
                    m_under = 1; m_sticky = 1;
                    m_cur_l = Mute ? '0 : m_last_l;
                    m_cur_r = Mute ? '0 : m_last_r;
                end
            end else begin
                m_slot++;
            end
            if (acc) begin
                m_hold_l = left_in; m_hold_r = right_in; m_hold_full = 1;
            end
        end
    endtask

    // {ready_out, ws, sdata, frame_start, underrun, underrun_sticky}
    function automatic logic [5:0] exp_vec();
        logic ews, esd, efs;
        ews = 0; esd = 0; efs = 0;
        if (m_run) begin
            ews = (m_slot >= W - 1) && (m_slot <= 2 * W - 2);
            esd = (m_slot < W) ? m_cur_l[W-1-m_slot] : m_cur_r[2*W-1-m_slot];
            efs = (m_slot == 0);
        end
        return {!m_hold_full, ews, esd, efs, m_under, m_sticky};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {ready_out, ws, sdata, frame_start, underrun, underrun_sticky};
    endfunction

    task automatic cycle();
        @(posedge sclk);
        model_step();
        @(negedge sclk);
    endtask

    task automatic do_reset();
        valid_in = 0;
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic accept_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        left_in = l; right_in = r; valid_in = 1;
        cycle();
        valid_in = 0;
        left_in = W'($urandom); right_in = W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1; valid_in = 0;
        cycle();
        vectors++;
        if (obs_vec() !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset: outputs got %b expected %b", obs_vec(), 6'b100000);
        end
        rst = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== 6'b100000 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL idle cyc %0d: outputs got %b expected %b", i, obs_vec(), 6'b100000);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [2*W-1:0] word = '0;
        do_reset();
        accept_pair(16'hDEAD, 16'hBEEF);
        vectors++;
        if (ready_out !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ready: ready_out got %b expected 0", ready_out);
        end
        for (int i = 0; i < 2 * W; i++) begin
            cycle();
            word = {word[2*W-2:0], sdata};
            vectors++;
            if (obs_vec() !== exp_vec() || ws !== (i >= W - 1 && i <= 2 * W - 2)
                || frame_start !== (i == 0)) begin
                miscompares++;
                $display("FAIL single_frame slot %0d: outputs got %b expected %b",
                         i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (word !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_decode: got %h expected deadbeef", word);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] word = '0;
        do_reset();
        accept_pair(16'hDEAD, 16'hBEEF);
        for (int i = 0; i < 2 * W; i++) begin
            if (i == 5) begin
                left_in = 16'h1234; right_in = 16'h5678; valid_in = 1;
            end else begin
                valid_in = 0;
            end
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b_frame1 slot %0d: outputs got %b expected %b",
                         i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 2 * W; i++) begin
            cycle();
            word = {word[2*W-2:0], sdata};
            vectors++;
            if (obs_vec() !== exp_vec() || underrun !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_frame2 slot %0d: outputs got %b expected %b",
                         i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (word !== 32'h12345678) begin
            miscompares++;
            $display("FAIL b2b_decode: got %h expected 12345678", word);
        end
    endtask

    task automatic test_underrun();
        logic [2*W-1:0] word = '0;
        logic [2*W-1:0] want;
        want = Mute ? 32'h0 : 32'hDEADBEEF;
        do_reset();
        accept_pair(16'hDEAD, 16'hBEEF);
        for (int i = 0; i < 4 * W; i++) begin
            cycle();
            if (i >= 2 * W) word = {word[2*W-2:0], sdata};
            vectors++;
            if (obs_vec() !== exp_vec() || underrun !== (i == 2 * W)) begin
                miscompares++;
                $display("FAIL underrun cyc %0d: outputs got %b expected %b",
                         i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (word !== want || underrun_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_decode: got %h sticky %b expected %h sticky 1",
                     word, underrun_sticky, want);
        end
    endtask

    task automatic test_boundary_accept();
        logic [2*W-1:0] word = '0;
        logic [2*W-1:0] a, b, want;
        a = $urandom; b = $urandom;
        want = Mute ? '0 : a;
        do_reset();
        accept_pair(a[2*W-1:W], a[W-1:0]);
        for (int i = 0; i < 2 * W; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL bnd_frame1 slot %0d: outputs got %b expected %b",
                         i, obs_vec(), exp_vec());
            end
        end
        // Accept lands on the edge that leaves the last slot.
        accept_pair(b[2*W-1:W], b[W-1:0]);
        vectors++;
        if (underrun !== 1'b1 || ready_out !== 1'b0 || frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL bnd_edge: underrun %b ready %b fs %b expected 1 0 1",
                     underrun, ready_out, frame_start);
        end
        word = {word[2*W-2:0], sdata};
        for (int i = 1; i < 4 * W; i++) begin
            cycle();
            if (i == 2 * W) begin
                vectors++;
                if (word !== want) begin
                    miscompares++;
                    $display("FAIL bnd_underrun_decode: got %h expected %h", word, want);
                end
            end
            word = {word[2*W-2:0], sdata};
            vectors++;
            if (obs_vec() !== exp_vec() || (i == 2 * W && underrun !== 1'b0)) begin
                miscompares++;
                $display("FAIL bnd_frames cyc %0d: outputs got %b expected %b",
                         i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (word !== b) begin
            miscompares++;
            $display("FAIL bnd_late_decode: got %h expected %h", word, b);
        end
    endtask

    task automatic test_mid_reset();
        logic [2*W-1:0] word = '0;
        do_reset();
        accept_pair(W'($urandom), W'($urandom));
        // Frame 1 plus slots 0..20 of the (underrunning) frame 2.
        for (int i = 0; i < 2 * W + 21; i++) begin
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL midrst_pre cyc %0d: outputs got %b expected %b",
                         i, obs_vec(), exp_vec());
            end
        end
        rst = 1;
        cycle();
        rst = 0;
        vectors++;
        if (obs_vec() !== 6'b100000) begin
            miscompares++;
            $display("FAIL midrst_reset: outputs got %b expected %b", obs_vec(), 6'b100000);
        end
        cycle();
        accept_pair(16'h8001, 16'h7FFE);
        vectors++;
        if (sdata !== 1'b0 || ready_out !== 1'b0 || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_accept: sdata %b ready %b fs %b expected 0 0 0",
                     sdata, ready_out, frame_start);
        end
        for (int i = 0; i < 2 * W; i++) begin
            cycle();
            word = {word[2*W-2:0], sdata};
            vectors++;
            if (obs_vec() !== exp_vec() || (i == 0 && (sdata !== 1'b1 || frame_start !== 1'b1))) begin
                miscompares++;
                $display("FAIL midrst_frame slot %0d: outputs got %b expected %b",
                         i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (word !== 32'h80017FFE) begin
            miscompares++;
            $display("FAIL midrst_decode: got %h expected 80017ffe", word);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            valid_in = ($urandom_range(0, 29) == 0);
            left_in  = W'($urandom);
            right_in = W'($urandom);
            rst      = ($urandom_range(0, 599) == 0);
            cycle();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: outputs got %b expected %b",
                         i, obs_vec(), exp_vec());
            end
        end
        rst = 0;
        valid_in = 0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underrun();
        test_boundary_accept();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
